ifetch_bridge: RTL

Memory-side bridge for the instruction fetch unit. It terminates the fetch request/response handshake (`if_req_*` / `if_resp_*`) and drives a single-port synchronous-read instruction SRAM. Fetch requests are checked for alignment and range, and up to FIFO_DEPTH requests can be in flight. Responses return in request order through a response FIFO, and a flush discards everything in flight on a redirect.

---
 rtl/ifetch_bridge_pkg.sv | 12 +
 rtl/ifetch_bridge_if.sv | 32 +++
 rtl/ifetch_bridge_sync_fifo.sv | 46 ++++
 rtl/ifetch_bridge.sv | 75 +++++++
 4 files changed

// File: rtl/ifetch_bridge_pkg.sv
// Shared constants for the instruction-fetch memory bridge.
// Width defaults mirror the core-wide fetch and instruction widths.
package ifetch_bridge_pkg;

  localparam int unsigned PC_WIDTH    = 32;
  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned MEM_AW      = 14;
  localparam int unsigned FIFO_DEPTH  = 4;

  localparam logic [PC_WIDTH-1:0] BASE_ADDR = 32'h8000_0000;

endpackage

// File: rtl/ifetch_bridge_if.sv
// Fetch request/response handshake plus SRAM port, grouped as one bus.
// The slave modport is the bridge's view; master is the fetch unit/SRAM side.
interface ifetch_bridge_if #(
  parameter int unsigned PC_WIDTH    = ifetch_bridge_pkg::PC_WIDTH,
  parameter int unsigned INSTR_WIDTH = ifetch_bridge_pkg::INSTR_WIDTH,
  parameter int unsigned MEM_AW      = ifetch_bridge_pkg::MEM_AW
);

   logic                   if_req_valid_i;
   logic                   if_req_ready_o;
   logic [PC_WIDTH-1:0]    if_req_pc_i;
   logic                   if_resp_valid_o;
   logic                   if_resp_ready_i;
   logic                   if_resp_err_o;
   logic [INSTR_WIDTH-1:0] if_resp_instr_o;
   logic                   mem_en_o;
   logic [MEM_AW-1:0]      mem_addr_o;
   logic [INSTR_WIDTH-1:0] mem_rdata_i;

   modport slave (
      input  if_req_valid_i, if_req_pc_i, if_resp_ready_i, mem_rdata_i,
      output if_req_ready_o, if_resp_valid_o, if_resp_err_o, if_resp_instr_o,
             mem_en_o, mem_addr_o
   );

   modport master (
      output if_req_valid_i, if_req_pc_i, if_resp_ready_i, mem_rdata_i,
      input  if_req_ready_o, if_resp_valid_o, if_resp_err_o, if_resp_instr_o,
             mem_en_o, mem_addr_o
   );

endinterface

// File: rtl/ifetch_bridge_sync_fifo.sv
// Synchronous FIFO with clear; head data reads as zero while empty.
// Push and pop may coincide at any occupancy, including full.
module sync_fifo #(
   parameter int unsigned WIDTH = 33,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q, rptr_q;
   logic             do_push, do_pop;

   // Extra pointer bit distinguishes full from empty.
   assign count   = wptr_q - rptr_q;
   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = empty ? '0 : mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !rst && !clr) mem_q[wptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/ifetch_bridge.sv
// Fetch-side SRAM bridge: fault check, one-cycle S1 stage for the SRAM read,
// and a credit-limited in-order response FIFO that flush/reset empties.
module ifetch_bridge
   import ifetch_bridge_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = ifetch_bridge_pkg::FIFO_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   ifetch_bridge_if.slave   bus
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH);

   logic [PC_WIDTH-1:0] pc_off;
   logic                misaligned, out_of_range, fault, accept;
   logic                s1_valid_q, s1_err_q;
   logic [CW:0]         fifo_count;
   logic [CW+1:0]       in_flight;
   logic                fifo_empty, fifo_full;
   logic [INSTR_WIDTH:0] fifo_wdata, fifo_rdata;
   logic                unused_off;

   // Below-base addresses wrap to huge offsets and so fault as out of range.
   assign pc_off       = bus.if_req_pc_i - BASE_ADDR;
   assign misaligned   = |bus.if_req_pc_i[1:0];
   assign out_of_range = |pc_off[PC_WIDTH-1:MEM_AW+2];
   assign fault        = misaligned || out_of_range;
   assign unused_off   = ^pc_off[1:0];

   // No lookahead on a same-cycle pop keeps resp_ready off the req_ready path.
   assign in_flight          = (CW+2)'(s1_valid_q) + (CW+2)'(fifo_count);
   assign bus.if_req_ready_o = !rst && !flush_i && (in_flight < (CW+2)'(FIFO_DEPTH));
   assign accept             = bus.if_req_valid_i && bus.if_req_ready_o;

   assign bus.mem_en_o   = accept && !fault;
   assign bus.mem_addr_o = pc_off[MEM_AW+1:2];

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         s1_valid_q <= 1'b0;
         s1_err_q   <= 1'b0;
      end else begin
         s1_valid_q <= accept;
         s1_err_q   <= accept && fault;
      end
   end

   assign fifo_wdata = {s1_err_q, s1_err_q ? '0 : bus.mem_rdata_i};

   sync_fifo #(
      .WIDTH (INSTR_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_resp_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush_i),
      .push  (s1_valid_q),
      .pop   (bus.if_resp_valid_o && bus.if_resp_ready_i),
      .wdata (fifo_wdata),
      .rdata (fifo_rdata),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   assign bus.if_resp_valid_o = !fifo_empty;
   assign bus.if_resp_err_o   = fifo_rdata[INSTR_WIDTH];
   assign bus.if_resp_instr_o = fifo_rdata[INSTR_WIDTH-1:0];

   logic unused_full;
   assign unused_full = fifo_full;

endmodule
